// File: rtl/sensor_ctrl_mc.sv
// Multi-channel sensor capture controller: per-channel sample buffers with
// stop/ring fill modes, sticky overwrite and threshold-interrupt flags.

module sensor_ctrl_ch #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic              mode,
  input  logic [AW:0]       thresh,
  input  logic              ready,
  input  logic [DATA_W-1:0] sample,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [AW:0]       count,
  output logic              full,
  output logic              ovf,
  output logic              irq,
  output logic              sensor_en
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [AW-1:0]                wptr;
  logic [AW:0]                  next_count;
  logic [AW-1:0]                base;
  logic                         cap;

  assign full       = (count == FULL_CNT);
  assign sensor_en  = en & ~clear & (~full | mode);
  assign cap        = sensor_en & ready;
  assign next_count = (cap && !full) ? count + (AW+1)'(1) : count;

  // Once full, the oldest entry sits at wptr; before that it is slot 0.
  assign base    = full ? wptr : '0;
  assign rd_data = mem[base + rd_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem   <= '0;
      wptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      irq   <= 1'b0;
    end else if (clear) begin
      wptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (cap) begin
        mem[wptr] <= sample;
        wptr      <= wptr + AW'(1);
        if (full) ovf <= 1'b1;
      end
      count <= next_count;
      // next_count covers both a crossing capture and a lowered threshold
      if (thresh != '0 && next_count >= thresh) irq <= 1'b1;
    end
  end
endmodule

module sensor_ctrl_mc #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int NCH    = 4,
  parameter int AW     = $clog2(DEPTH),
  parameter int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        sctrl_en,
  input  logic [NCH-1:0]        sctrl_clear,
  input  logic                  sctrl_mode,
  input  logic [AW:0]           sctrl_thresh,
  input  logic [CW-1:0]         sctrl_ch,
  input  logic [AW-1:0]         sctrl_addr,
  input  logic [NCH-1:0]        sensor_ready,
  input  logic [NCH*DATA_W-1:0] sensor_out,
  output logic [DATA_W-1:0]     sctrl_out,
  output logic [AW:0]           sctrl_count,
  output logic [NCH-1:0]        sctrl_full,
  output logic [NCH-1:0]        sctrl_ovf,
  output logic [NCH-1:0]        sctrl_irq_status,
  output logic                  sctrl_interrupt,
  output logic [NCH-1:0]        sensor_en
);
  logic [NCH-1:0][DATA_W-1:0] rd_data;
  logic [NCH-1:0][AW:0]       cnt;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    sensor_ctrl_ch #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (sctrl_en[c]),
      .clear     (sctrl_clear[c]),
      .mode      (sctrl_mode),
      .thresh    (sctrl_thresh),
      .ready     (sensor_ready[c]),
      .sample    (sensor_out[c*DATA_W +: DATA_W]),
      .rd_addr   (sctrl_addr),
      .rd_data   (rd_data[c]),
      .count     (cnt[c]),
      .full      (sctrl_full[c]),
      .ovf       (sctrl_ovf[c]),
      .irq       (sctrl_irq_status[c]),
      .sensor_en (sensor_en[c])
    );
  end

  assign sctrl_interrupt = |sctrl_irq_status;

  // Compare-select rather than index so channel numbers >= NCH read as zero.
  always_comb begin
    sctrl_out   = '0;
    sctrl_count = '0;
    for (int c = 0; c < NCH; c++) begin
      if (sctrl_ch == CW'(c)) begin
        sctrl_out   = rd_data[c];
        sctrl_count = cnt[c];
      end
    end
  end
endmodule

// File: doc/sensor_ctrl_mc.md
SENSOR_CTRL_MC -- requirements
Module: sensor_ctrl_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 32, sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, entries per channel; power of two, >=2; AW = log2(DEPTH).
REQ-003 SHALL have parameter NCH, default 4, sensor channel count, >=1; CW = max(1, log2(NCH)).
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- sctrl_en  in  NCH  per-channel capture enable.
- sctrl_clear  in  NCH  per-channel clear.
- sctrl_mode  in  1  0 = stop-when-full, 1 = ring (overwrite oldest).
- sctrl_thresh  in  AW+1  interrupt threshold; 0 = threshold disabled.
- sctrl_ch  in  CW  read channel select.
- sctrl_addr  in  AW  logical read index; 0 = oldest entry.
- sensor_ready  in  NCH  per-channel sample valid.
- sensor_out  in  NCH*DATA_W  samples; channel c at bits [c*DATA_W +: DATA_W].
- sctrl_out  out  DATA_W  read data.
- sctrl_count  out  AW+1  entry count of selected channel.
- sctrl_full  out  NCH  per-channel full flag.
- sctrl_ovf  out  NCH  per-channel sticky overwrite flag.
- sctrl_irq_status  out  NCH  per-channel sticky interrupt cause.
- sctrl_interrupt  out  1  OR of sctrl_irq_status.
- sensor_en  out  NCH  per-channel sensor enable.

Function
REQ-005 Each channel SHALL own an independent DEPTH x DATA_W buffer, write pointer wptr (AW bits), and count (AW+1 bits, 0..DEPTH).
REQ-006 sensor_en[c] SHALL be combinational: sctrl_en[c] & ~sctrl_clear[c] & (~full[c] | sctrl_mode).
REQ-007 Capture on channel c SHALL occur when sensor_en[c] & sensor_ready[c]: buf[c][wptr] <= sample; wptr <= wptr+1 mod DEPTH.
REQ-008 On capture, count SHALL increment while below DEPTH, then saturate at DEPTH.
REQ-009 full[c] SHALL equal (count[c] == DEPTH).
REQ-010 Stop mode SHALL accept no captures while full; ring mode SHALL accept them and overwrite the oldest entry.
REQ-011 A capture while full in ring mode SHALL set sctrl_ovf[c]; the flag is sticky until clear or reset.
REQ-012 Read SHALL be combinational: sctrl_out = buf[ch][(base + sctrl_addr) mod DEPTH], where base = wptr[ch] if full[ch], else 0.
REQ-013 A sample captured at edge N SHALL be readable, and counted in sctrl_count, from cycle N+1.
REQ-014 For sctrl_ch >= NCH, sctrl_out and sctrl_count SHALL be 0.
REQ-015 sctrl_irq_status[c] SHALL set at the edge where count[c] becomes >= sctrl_thresh with sctrl_thresh != 0, and SHALL stay set until clear or reset.
REQ-016 Lowering sctrl_thresh to or below the current count SHALL set irq_status on the next edge.
REQ-017 sctrl_clear[c] SHALL zero wptr, count, full, ovf and irq_status of channel c on the next edge, and SHALL win over a same-cycle capture.
REQ-018 Clear SHALL leave buffer contents and all other channels unchanged.
REQ-019 Mode SHALL be sampled every cycle with no pointer changes.
REQ-020 A stop->ring switch while full SHALL resume capture at wptr (=0).
REQ-021 A ring->stop switch while full SHALL halt capture.
REQ-022 Channels SHALL operate concurrently; simultaneous captures on all channels SHALL all complete in the same cycle.

Reset
REQ-023 On rst = 1 at posedge, all wptr, count, full, ovf, irq_status and all buffer entries SHALL become 0.
REQ-024 Reset SHALL take priority over clear and capture, including mid-fill.
REQ-025 While in reset, and in the cycle after, outputs SHALL be: sctrl_out = 0, sctrl_count = 0, sctrl_interrupt = 0, sensor_en = sctrl_en & ~sctrl_clear.

Verification
REQ-026 Stop fill: mode=0, ch0 en+ready continuously, samples 1..70 -> after 64 captures full[0]=1, sensor_en[0]=0, addr 0..63 read 1..64, ovf[0]=0.
REQ-027 Ring wrap: mode=1, 70 samples 1..70 on ch1 -> count=64, ovf[1]=1, addr 0 reads 7, addr 63 reads 70.
REQ-028 Threshold: thresh=5, ch2 gets 5 samples -> irq_status[2]=1 and sctrl_interrupt=1 exactly at the 5th capture edge; clear[2] -> both 0 next cycle, count=0.
REQ-029 Clear vs capture: clear[3]=1 with en+ready in the same cycle -> count[3]=0, sample not counted; ch0..2 counts unchanged.
REQ-030 Concurrency/reset: all 4 channels capture 10 samples simultaneously -> each count=10; rst pulse mid-fill -> all counts 0, sctrl_out=0 for every ch/addr.
